sc_dmem_io: RTL and testbench

Data-side memory responder for the single-cycle CPU: answers the CPU's load/store port (address, write data, write enable in; read data out) within the same cycle. It holds a small data RAM plus memory-mapped peripherals: LED register, synchronised switch input, free-running timer with compare flag, and a byte TX FIFO drained by a valid/ready sink. It sits between the CPU's data bus and the board I/O.

---
 rtl/sc_io_pkg.sv | 51 +++++
 rtl/io_fifo.sv | 59 +++++
 rtl/sc_dmem_io.sv | 135 +++++++++++++
 tb/tb_sc_dmem_io.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_io_pkg.sv
// Address map and STATUS layout shared by the data-side memory responder.
package sc_io_pkg;

  // Byte offsets within the 256-byte window (addr[7:0]).
  localparam logic [7:0] OFF_LED    = 8'h80;
  localparam logic [7:0] OFF_SW     = 8'h84;
  localparam logic [7:0] OFF_TCOUNT = 8'h88;
  localparam logic [7:0] OFF_TCMP   = 8'h8C;
  localparam logic [7:0] OFF_STATUS = 8'h90;
  localparam logic [7:0] OFF_TX     = 8'h94;

  // STATUS register bit positions.
  localparam int ST_TFLAG  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_OCC_LO = 4;
  localparam int ST_OCC_W  = 3;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_TCOUNT,
    REG_TCMP,
    REG_STATUS,
    REG_TX,
    REG_NONE
  } region_e;

  // Map a word offset (addr[7:2]) to the region it selects.
  function automatic region_e decode_region(input logic [5:0] word);
    region_e r;
    r = REG_NONE;
    if (!word[5]) begin
      r = REG_RAM;
    end else begin
      case (word)
        OFF_LED[7:2]:    r = REG_LED;
        OFF_SW[7:2]:     r = REG_SW;
        OFF_TCOUNT[7:2]: r = REG_TCOUNT;
        OFF_TCMP[7:2]:   r = REG_TCMP;
        OFF_STATUS[7:2]: r = REG_STATUS;
        OFF_TX[7:2]:     r = REG_TX;
        default:         r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Small byte FIFO for the TX path: push/pop with full/empty/occupancy.
// A push while full is accepted only when a pop frees a slot the same cycle.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  // Empty FIFO presents zero rather than a stale slot.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write on accepted push.
  // NOTE: storage arrays carry no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sc_dmem_io.sv
// Data-side memory responder: data RAM, LED, synchronised switches,
// free-running timer with sticky compare flag, and a TX byte FIFO.
module sc_dmem_io
  import sc_io_pkg::*;
#(
  parameter int RAM_WORDS  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SW_W       = 10
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  output logic [31:0]     rdata,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] led,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  region_e             region;
  logic [RAM_AW-1:0]   ram_idx;
  logic [31:0]         ram [RAM_WORDS];
  logic [SW_W-1:0]     sw_meta;
  logic [SW_W-1:0]     sw_sync;
  logic [31:0]         tcount;
  logic [31:0]         tcmp;
  logic                tflag;
  logic                ovf;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_drop;
  logic                pop;
  logic [31:0]         status;
  logic                wr_ram, wr_led, wr_tcount, wr_tcmp, wr_status, wr_tx;
  logic                unused_addr;

  // Upper bits alias the 256-byte window; low bits are byte lanes we ignore.
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  assign region    = decode_region(addr[7:2]);
  assign ram_idx   = addr[RAM_AW+1:2];
  assign wr_ram    = we && (region == REG_RAM);
  assign wr_led    = we && (region == REG_LED);
  assign wr_tcount = we && (region == REG_TCOUNT);
  assign wr_tcmp   = we && (region == REG_TCMP);
  assign wr_status = we && (region == REG_STATUS);
  assign wr_tx     = we && (region == REG_TX);

  assign tx_valid  = !fifo_empty;
  assign pop       = tx_valid && tx_ready;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (wr_tx),
    .din    (wdata[7:0]),
    .pop    (pop),
    .dout   (tx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .drop   (fifo_drop)
  );

  // Data RAM store port; loads read the array combinationally.
  always_ff @(posedge clock) begin
    if (wr_ram) ram[ram_idx] <= wdata;
  end

  // LED register and two-flop switch synchroniser.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (wr_led) led <= wdata[SW_W-1:0];
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Timer, compare flag and overflow flag; a set always wins over a clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcount <= '0;
      tcmp   <= '1;
      tflag  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      tcount <= wr_tcount ? wdata : tcount + 32'd1;
      if (wr_tcmp) tcmp <= wdata;
      if (tcount == tcmp)                    tflag <= 1'b1;
      else if (wr_status && wdata[ST_TFLAG]) tflag <= 1'b0;
      if (fifo_drop)                         ovf <= 1'b1;
      else if (wr_status && wdata[ST_OVF])   ovf <= 1'b0;
    end
  end

  // Assemble the STATUS word.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    status                          = '0;
    status[ST_TFLAG]                = tflag;
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = ovf;
    status[ST_OCC_LO +: ST_OCC_W]   = ST_OCC_W'(fifo_count);
  end

  // Load data mux, zero-latency from address and registered state.
  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM:    rdata = ram[ram_idx];
      REG_LED:    rdata = 32'(led);
      REG_SW:     rdata = 32'(sw_sync);
      REG_TCOUNT: rdata = tcount;
      REG_TCMP:   rdata = tcmp;
      REG_STATUS: rdata = status;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sc_dmem_io.sv
// Self-checking bench for sc_dmem_io: directed vector table, randomized
// traffic against a behavioural model, and a mid-cycle reset sequence.
module tb_sc_dmem_io;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [9:0]  sw;
  logic [9:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_tests = 0;
  int n_fail  = 0;

  sc_dmem_io #(
    .RAM_WORDS  (32),
    .FIFO_DEPTH (4),
    .SW_W       (10)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .sw       (sw),
    .led      (led),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_ram [32];
  bit          m_ram_ok [32];
  logic [9:0]  m_led;
  logic [9:0]  m_sw_1edge;
  logic [9:0]  m_sw_2edge;
  logic [31:0] m_tcount;
  logic [31:0] m_tcmp;
  bit          m_tflag;
  bit          m_ovf;
  logic [7:0]  m_fifo [$];
  logic [7:0]  dut_out [$];

  function automatic void model_reset();
    m_led      = '0;
    m_sw_1edge = '0;
    m_sw_2edge = '0;
    m_tcount   = 32'd0;
    m_tcmp     = 32'hFFFF_FFFF;
    m_tflag    = 1'b0;
    m_ovf      = 1'b0;
    m_fifo.delete();
  endfunction

  // Returns 1 when the model knows the value (RAM words never stored are unknown).
  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    int off;
    int n;
    off = int'(a[7:0]) / 4 * 4;
    n   = m_fifo.size();
    v   = 32'd0;
    if (off < 128) begin
      v = m_ram[off/4];
      return m_ram_ok[off/4];
    end
    case (off)
      128: v = 32'(m_led);
      132: v = 32'(m_sw_2edge);
      136: v = m_tcount;
      140: v = m_tcmp;
      144: v = 32'(int'(m_tflag) + 2 * int'(n == 4) + 4 * int'(n == 0)
                   + 8 * int'(m_ovf) + 16 * n);
      default: v = 32'd0;
    endcase
    return 1'b1;
  endfunction

  function automatic void model_step(input logic [31:0] a, input logic [31:0] wd,
                                     input bit w, input logic [9:0] s, input bit rdy);
    int          off;
    bit          popped;
    bit          match;
    bit          clr_t;
    bit          clr_o;
    bit          set_o;
    logic [31:0] next_tc;
    off     = int'(a[7:0]) / 4 * 4;
    popped  = (m_fifo.size() > 0) && rdy;
    match   = (m_tcount == m_tcmp);
    next_tc = m_tcount + 32'd1;
    clr_t   = 1'b0;
    clr_o   = 1'b0;
    set_o   = 1'b0;
    if (popped) void'(m_fifo.pop_front());
    if (w) begin
      if (off < 128) begin
        m_ram[off/4]    = wd;
        m_ram_ok[off/4] = 1'b1;
      end
      case (off)
        128: m_led   = wd[9:0];
        136: next_tc = wd;
        140: m_tcmp  = wd;
        144: begin clr_t = wd[0]; clr_o = wd[3]; end
        148: begin
          if (m_fifo.size() < 4) m_fifo.push_back(wd[7:0]);
          else set_o = 1'b1;
        end
        default: ;
      endcase
    end
    if (match)      m_tflag = 1'b1;
    else if (clr_t) m_tflag = 1'b0;
    if (set_o)      m_ovf = 1'b1;
    else if (clr_o) m_ovf = 1'b0;
    m_tcount   = next_tc;
    m_sw_2edge = m_sw_1edge;
    m_sw_1edge = s;
  endfunction

  // One bus cycle: called at a falling edge, returns at the next falling edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] wd, input bit w,
                       input logic [9:0] s, input bit rdy,
                       input bit chk, input logic [31:0] exp, input string name);
    logic [31:0] mv;
    addr = a; wdata = wd; we = w; sw = s; tx_ready = rdy;
    #1;
    if (model_read(a, mv)) check("rdata_vs_model", rdata, mv);
    check("led_vs_model", 32'(led), 32'(m_led));
    check("tx_valid_vs_model", 32'(tx_valid), 32'(m_fifo.size() > 0));
    check("tx_data_vs_model", 32'(tx_data), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
    if (chk) check(name, rdata, exp);
    if (tx_valid && tx_ready) dut_out.push_back(tx_data);
    @(posedge clock);
    model_step(a, wd, w, s, rdy);
    @(negedge clock);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    logic [9:0]  sw;
    bit          rdy;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic [31:0] a, input logic [31:0] wd, input bit w,
                              input logic [9:0] s, input bit rdy, input bit chk,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.addr = a; v.wdata = wd; v.we = w; v.sw = s; v.rdy = rdy;
    v.chk = chk; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0]  exp_out [5];
    logic [31:0] a;
    logic [31:0] wd;
    logic [9:0]  cur_sw;
    int          pick;

    addr = '0; wdata = '0; we = 1'b0; sw = '0; tx_ready = 1'b0;
    resetn = 1'b0;
    model_reset();

    // RAM, aliasing, unmapped
    add(32'h10,  32'hDEADBEEF, 1, 10'h000, 0, 0, 32'h0,        "");
    add(32'h10,  32'h0,        0, 10'h000, 0, 1, 32'hDEADBEEF, "ram_load");
    add(32'h110, 32'h0,        0, 10'h000, 0, 1, 32'hDEADBEEF, "ram_alias");
    add(32'h98,  32'h0,        0, 10'h000, 0, 1, 32'h0,        "unmapped_read");
    // LED and switch sync
    add(32'h80,  32'h3FF,      1, 10'h000, 0, 1, 32'h0,        "led_old_on_store");
    add(32'h80,  32'h0,        0, 10'h155, 0, 1, 32'h3FF,      "led_read");
    add(32'h84,  32'h0,        0, 10'h155, 0, 1, 32'h0,        "sw_after_one_edge");
    add(32'h84,  32'h0,        0, 10'h155, 0, 1, 32'h155,      "sw_after_two_edges");
    // Timer: TCMP=5 then TCOUNT=0
    add(32'h8C,  32'h5,        1, 10'h155, 0, 0, 32'h0,        "");
    add(32'h88,  32'h0,        1, 10'h155, 0, 0, 32'h0,        "");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4,        "status_idle");
    add(32'h88,  32'h0,        0, 10'h155, 0, 1, 32'h1,        "tcount_running");
    add(32'h8C,  32'h0,        0, 10'h155, 0, 1, 32'h5,        "tcmp_read");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4,        "tflag_clear_c3");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4,        "tflag_clear_c4");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4,        "tflag_clear_on_match");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h5,        "tflag_set");
    add(32'h90,  32'h1,        1, 10'h155, 0, 1, 32'h5,        "status_old_on_clear");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4,        "tflag_cleared");
    // FIFO fill past full with sink stalled
    add(32'h94,  32'h41,       1, 10'h155, 0, 1, 32'h0,        "tx_reads_zero");
    add(32'h94,  32'h42,       1, 10'h155, 0, 0, 32'h0,        "");
    add(32'h94,  32'h43,       1, 10'h155, 0, 0, 32'h0,        "");
    add(32'h94,  32'h44,       1, 10'h155, 0, 0, 32'h0,        "");
    add(32'h94,  32'h45,       1, 10'h155, 0, 0, 32'h0,        "");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4A,       "fifo_full_ovf");
    // Push and pop together while full
    add(32'h94,  32'h50,       1, 10'h155, 1, 0, 32'h0,        "");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4A,       "full_push_pop");
    // Clear ovf and drain
    add(32'h90,  32'h8,        1, 10'h155, 1, 0, 32'h0,        "");
    add(32'h90,  32'h0,        0, 10'h155, 1, 1, 32'h30,       "ovf_cleared");
    add(32'h90,  32'h0,        0, 10'h155, 1, 0, 32'h0,        "");
    add(32'h90,  32'h0,        0, 10'h155, 1, 0, 32'h0,        "");
    add(32'h90,  32'h0,        0, 10'h155, 0, 1, 32'h4,        "fifo_drained");

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    addr = 32'h8C; #1; check("reset_tcmp", rdata, 32'hFFFF_FFFF);
    addr = 32'h90; #1; check("reset_status", rdata, 32'h4);
    @(negedge clock);
    resetn = 1'b1;

    foreach (vecs[i])
      apply(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].sw, vecs[i].rdy,
            vecs[i].chk, vecs[i].exp, vecs[i].name);

    exp_out = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h50};
    check("delivered_count", 32'(dut_out.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("delivered_byte", (i < dut_out.size()) ? 32'(dut_out[i]) : 32'hFFFF_FFFF,
            32'(exp_out[i]));

    // Randomized traffic
    cur_sw = 10'h155;
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 9);
      wd   = $urandom;
      case (pick)
        0, 1: a = 32'($urandom_range(0, 31) * 4);
        2:    a = 32'h80;
        3:    a = 32'h84;
        4:    begin
          a = 32'h88;
          if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFFE;
          else wd = m_tcmp - 32'($urandom_range(0, 6));
        end
        5:    begin a = 32'h8C; wd = m_tcount + 32'($urandom_range(0, 8)); end
        6:    a = 32'h90;
        7, 8: a = 32'h94;
        default: a = 32'h80 + 32'($urandom_range(6, 31) * 4);
      endcase
      a = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), a[7:0]};
      if ($urandom_range(0, 15) == 0) cur_sw = 10'($urandom);
      apply(a, wd, $urandom_range(0, 1) == 1, cur_sw, $urandom_range(0, 2) == 0,
            0, 32'h0, "");
    end

    // Mid-traffic asynchronous reset
    apply(32'h80, 32'h2A5, 1, cur_sw, 0, 0, 32'h0, "");
    apply(32'h94, 32'h11,  1, cur_sw, 0, 0, 32'h0, "");
    apply(32'h94, 32'h22,  1, cur_sw, 0, 0, 32'h0, "");
    apply(32'h8C, 32'h1234, 1, cur_sw, 0, 0, 32'h0, "");
    we = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("async_rst_tx_data", 32'(tx_data), 32'h0);
    check("async_rst_led", 32'(led), 32'h0);
    addr = 32'h88; #1; check("async_rst_tcount", rdata, 32'h0);
    addr = 32'h8C; #1; check("async_rst_tcmp", rdata, 32'hFFFF_FFFF);
    addr = 32'h90; #1; check("async_rst_status", rdata, 32'h4);
    addr = 32'h84; #1; check("async_rst_sw", rdata, 32'h0);
    repeat (2) @(negedge clock);
    addr = 32'h88; #1; check("rst_held_tcount", rdata, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    apply(32'h88, 32'h0, 0, cur_sw, 0, 1, 32'h0, "tcount_after_release");
    apply(32'h88, 32'h0, 0, cur_sw, 0, 1, 32'h1, "tcount_counts_again");
    for (int i = 0; i < 40; i++)
      apply(32'h80 + 32'($urandom_range(0, 5) * 4), $urandom, $urandom_range(0, 1) == 1,
            cur_sw, $urandom_range(0, 1) == 1, 0, 32'h0, "");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
